// File: rtl/twos_comp_pkg.sv
// Shared constants and state encoding for the two's-complement dispatch slice.
// The default widths are also used by the complementer bench.
package twos_comp_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 32;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10,
        ST_OUT   = 2'b11
    } state_e;

    // Narrowest counter that can still hold timeout-1.
    function automatic int timer_width(input int timeout);
        if (timeout <= 2) begin
            return 1;
        end else begin
            return $clog2(timeout);
        end
    endfunction

endpackage

// File: rtl/twos_comp_watchdog.sv
// Conversion watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count reaches TIMEOUT-1.
module twos_comp_watchdog
    import twos_comp_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            TW   = timer_width(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: clear wins, otherwise advance only while enabled.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/twos_comp_dispatch.sv
// Valid/ready front end for the serial two's-complement FSM: one operand in
// flight, watchdog-bounded conversion, result presented with an error flag.
module twos_comp_dispatch
    import twos_comp_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_err,
    output logic              cmp_start,
    output logic [DATA_W-1:0] cmp_in,
    input  logic [DATA_W-1:0] cmp_out,
    input  logic              cmp_done,
    output logic              busy,
    output logic [CNT_W-1:0]  err_count
);

    state_e             state_q;
    state_e             state_d;
    logic [DATA_W-1:0]  op_q;
    logic [DATA_W-1:0]  op_d;
    logic [DATA_W-1:0]  res_q;
    logic [DATA_W-1:0]  res_d;
    logic               err_q;
    logic               err_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               s_ready_q;
    logic               cmp_start_q;
    logic               m_valid_q;
    logic               busy_q;
    logic               wd_clear_s;
    logic               wd_enable_s;
    logic               wd_expired_s;

    assign wd_enable_s = (state_q == ST_RUN);

    twos_comp_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // Next-state and datapath decisions.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        res_d      = res_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        wd_clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    op_d       = s_data;
                    wd_clear_s = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A done seen on the expiry cycle still counts as a good result.
                if (cmp_done) begin
                    res_d   = cmp_out;
                    err_d   = 1'b0;
                    state_d = ST_CLEAR;
                end else if (wd_expired_s) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_CLEAR;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CLEAR: begin
                if (!cmp_done) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output flags; flags are precomputed from state_d.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            s_ready_q   <= 1'b1;
            cmp_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            res_q       <= res_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            s_ready_q   <= (state_d == ST_IDLE);
            cmp_start_q <= (state_d == ST_RUN);
            m_valid_q   <= (state_d == ST_OUT);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign s_ready   = s_ready_q;
    assign cmp_start = cmp_start_q;
    assign m_valid   = m_valid_q;
    assign busy      = busy_q;
    assign cmp_in    = op_q;
    assign m_data    = res_q;
    assign m_err     = err_q;
    assign err_count = cnt_q;

endmodule
